// File: rtl/fetch_align_q.sv
// fetch_align_q
//   Decode front end directly upstream of the prefix decoder. It keeps
//   16-byte fetch lines in a circular byte buffer and presents 16 bytes that
//   start at the current instruction boundary. Decode reports how many bytes
//   it used, and the head advances by that amount. A redirect flush empties
//   the buffer. It then arranges for the next line to be entered at the byte
//   offset given by the new EIP.
//
//   Handshakes: a transfer on either interface happens on a rising clk edge
//   where the producer's valid and the consumer's ready are both 1. The
//   producer holds its data stable while valid=1 and ready=0. The consumer's
//   ready never depends combinationally on the producer's valid. A cycle
//   with flush=1 cancels any transfer that is presented in that cycle.
//
// Ports
//   clk          clock
//   reset        asynchronous reset, active low
//   line_in      fetched line, byte 0 on [127:120]
//   line_valid   line_in is valid
//   line_ready   a free line slot exists
//   flush        redirect; discards all buffered bytes
//   flush_eip    new EIP; bits [3:0] select the entry byte of the next line
//   packet       16 bytes from the head, head byte on [127:120]
//   pkt_valid    at least 16 bytes are buffered
//   pkt_eip      EIP of the head byte
//   pkt_ready    decode consumes this cycle
//   consume_len  bytes consumed, legal 1..16
//   len_err      one-cycle pulse after an illegal consume_len
module fetch_align_q #(
   parameter int DEPTH = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [127:0] line_in,
   input  logic         line_valid,
   output logic         line_ready,
   input  logic         flush,
   input  logic [31:0]  flush_eip,
   output logic [127:0] packet,
   output logic         pkt_valid,
   output logic [31:0]  pkt_eip,
   input  logic         pkt_ready,
   input  logic [4:0]   consume_len,
   output logic         len_err
);

   localparam int BUF_BYTES = DEPTH * 16;
   localparam int PTR_W     = $clog2(BUF_BYTES);
   localparam int CNT_W     = $clog2(BUF_BYTES + 1);
   localparam int SLOT_W    = (DEPTH > 2) ? 2 : 1;

   logic [127:0]      lines [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  byte_cnt;
   logic [SLOT_W-1:0] wr_slot;
   logic [3:0]        skip;
   logic [31:0]       eip;

   logic              len_ok;
   logic              do_write;
   logic              do_consume;
   logic              bad_len;
   logic [7:0]        fill_level;
   logic [7:0]        cnt_sum;
   logic [7:0]        ptr_sum;

   // Occupancy is counted from the start of the head's line. The offset of
   // the head within that line, and any pending entry skip, also hold
   // space, because writes always land on whole slots.
   assign fill_level = 8'(byte_cnt) + 8'(rd_ptr[3:0]) + 8'(skip);
   assign line_ready = (fill_level <= 8'((DEPTH - 1) * 16));
   assign pkt_valid  = (byte_cnt >= CNT_W'(16));
   assign pkt_eip    = eip;

   assign len_ok     = (consume_len != 5'd0) && (consume_len <= 5'd16);
   assign do_write   = line_valid && line_ready && !flush;
   assign do_consume = pkt_valid && pkt_ready && len_ok && !flush;
   assign bad_len    = pkt_valid && pkt_ready && !len_ok && !flush;

   always_comb begin
      cnt_sum = 8'(byte_cnt);
      if (do_write) begin
         cnt_sum = cnt_sum + 8'd16 - 8'(skip);
      end
      if (do_consume) begin
         cnt_sum = cnt_sum - 8'(consume_len);
      end
      // The buffer size need not be a power of two, so wrap explicitly.
      ptr_sum = 8'(rd_ptr) + 8'(consume_len);
      if (ptr_sum >= 8'(BUF_BYTES)) begin
         ptr_sum = ptr_sum - 8'(BUF_BYTES);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr   <= '0;
         byte_cnt <= '0;
         wr_slot  <= '0;
         skip     <= 4'd0;
         eip      <= 32'd0;
         len_err  <= 1'b0;
      end else if (flush) begin
         // The head starts at the entry byte of the line that arrives next.
         // That line goes into slot 0, so the entry offset also serves as
         // the read pointer.
         rd_ptr   <= PTR_W'(flush_eip[3:0]);
         byte_cnt <= '0;
         wr_slot  <= '0;
         skip     <= flush_eip[3:0];
         eip      <= flush_eip;
         len_err  <= 1'b0;
      end else begin
         byte_cnt <= cnt_sum[CNT_W-1:0];
         len_err  <= bad_len;
         if (do_write) begin
            wr_slot <= (wr_slot == SLOT_W'(DEPTH - 1)) ? '0 : wr_slot + 1'b1;
            skip    <= 4'd0;
         end
         if (do_consume) begin
            rd_ptr <= ptr_sum[PTR_W-1:0];
            eip    <= eip + 32'(consume_len);
         end
      end
   end

   // Line storage carries no reset; its contents are only observed through
   // byte_cnt.
   always_ff @(posedge clk) begin
      if (do_write) begin
         lines[wr_slot] <= line_in;
      end
   end

   // Barrel rotate: output byte i comes from buffer byte rd_ptr+i, wrapped.
   logic [7:0]   idx;
   logic [3:0]   sel;
   logic [127:0] src;

   always_comb begin
      packet = '0;
      idx    = 8'd0;
      sel    = 4'd0;
      src    = '0;
      for (int i = 0; i < 16; i++) begin
         idx = 8'(rd_ptr) + 8'(i);
         if (idx >= 8'(BUF_BYTES)) begin
            idx = idx - 8'(BUF_BYTES);
         end
         src = lines[idx[PTR_W-1:4]];
         sel = 4'd15 - idx[3:0];
         if (pkt_valid) begin
            packet[127-8*i -: 8] = src[{sel, 3'b000} +: 8];
         end
      end
   end

endmodule

// File: tb/tb_fetch_align_q.sv
// Bench for fetch_align_q. It applies a table of directed vectors with
// hand-derived expectations. It then runs a stream of 7-byte consumes that
// wraps the buffer, random traffic with flushes and illegal lengths, and a
// reset asserted mid-stream. Every cycle is compared against a byte-queue
// reference model.
module tb_fetch_align_q;

   localparam int DEPTH = 3;

   logic         clk;
   logic         reset;
   logic [127:0] line_in;
   logic         line_valid;
   logic         line_ready;
   logic         flush;
   logic [31:0]  flush_eip;
   logic [127:0] packet;
   logic         pkt_valid;
   logic [31:0]  pkt_eip;
   logic         pkt_ready;
   logic [4:0]   consume_len;
   logic         len_err;

   fetch_align_q #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .line_in     (line_in),
      .line_valid  (line_valid),
      .line_ready  (line_ready),
      .flush       (flush),
      .flush_eip   (flush_eip),
      .packet      (packet),
      .pkt_valid   (pkt_valid),
      .pkt_eip     (pkt_eip),
      .pkt_ready   (pkt_ready),
      .consume_len (consume_len),
      .len_err     (len_err)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard / reference model ----------------
   logic [7:0]  exp_q [$];   // buffered byte stream, head at index 0
   logic [31:0] m_eip;
   logic [3:0]  m_skip;      // entry bytes still to drop from the next line
   logic        m_len_err;
   int          n_checks;
   int          n_errors;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] seq_line(input logic [7:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s + 8'(i);
      return r;
   endfunction

   // The head's line offset always equals the EIP low nibble. The space in
   // use is therefore the queued bytes plus that offset plus any pending
   // entry skip.
   function automatic logic model_ready();
      return (exp_q.size() + int'(m_eip[3:0]) + int'(m_skip)) <= (DEPTH - 1) * 16;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_eip     = 32'd0;
      m_skip    = 4'd0;
      m_len_err = 1'b0;
   endtask

   task automatic model_update(input logic lv, input logic [127:0] ln, input logic fl,
                               input logic [31:0] fe, input logic pr, input logic [4:0] len);
      logic wr;
      logic valid;
      wr    = lv && model_ready() && !fl;
      valid = exp_q.size() >= 16;
      m_len_err = 1'b0;
      if (fl) begin
         exp_q.delete();
         m_eip  = fe;
         m_skip = fe[3:0];
         return;
      end
      if (valid && pr) begin
         if (len >= 5'd1 && len <= 5'd16) begin
            repeat (len) void'(exp_q.pop_front());
            m_eip = m_eip + 32'(len);
         end else begin
            m_len_err = 1'b1;
         end
      end
      if (wr) begin
         for (int b = int'(m_skip); b < 16; b++) exp_q.push_back(ln[127-8*b -: 8]);
         m_skip = 4'd0;
      end
   endtask

   task automatic check_model();
      logic [127:0] exp_pkt;
      logic         exp_valid;
      exp_valid = exp_q.size() >= 16;
      exp_pkt   = '0;
      if (exp_valid) begin
         for (int i = 0; i < 16; i++) exp_pkt[127-8*i -: 8] = exp_q[i];
      end
      chk("model pkt_valid", 128'(pkt_valid), 128'(exp_valid));
      chk("model line_ready", 128'(line_ready), 128'(model_ready()));
      chk("model packet", packet, exp_pkt);
      chk("model pkt_eip", 128'(pkt_eip), 128'(m_eip));
      chk("model len_err", 128'(len_err), 128'(m_len_err));
   endtask

   // ---------------- driver ----------------
   // Inputs change 1 time unit after a rising edge. Outputs are sampled at
   // that same point, after the edge has been applied to the model.
   task automatic step(input logic lv, input logic [127:0] ln, input logic fl,
                       input logic [31:0] fe, input logic pr, input logic [4:0] len);
      line_valid  = lv;
      line_in     = ln;
      flush       = fl;
      flush_eip   = fe;
      pkt_ready   = pr;
      consume_len = len;
      @(posedge clk);
      model_update(lv, ln, fl, fe, pr, len);
      #1;
      check_model();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct packed {
      logic        lv;
      logic [7:0]  ln_start;
      logic        fl;
      logic [31:0] fe;
      logic        pr;
      logic [4:0]  len;
      logic        e_valid;
      logic        e_ready;
      logic [31:0] e_eip;
      logic        e_lerr;
      logic [7:0]  e_head;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];

   logic        r_lv;
   logic        r_fl;
   logic        r_pr;
   logic        acc;
   logic [31:0] r_fe;
   logic [4:0]  r_len;
   int          nl;

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      reset       = 1'b0;
      line_valid  = 1'b0;
      line_in     = '0;
      flush       = 1'b0;
      flush_eip   = 32'd0;
      pkt_ready   = 1'b0;
      consume_len = 5'd0;
      model_reset();

      //            lv  start  fl  flush_eip     pr  len     valid ready eip           lerr head
      vecs[0]  = '{1'b1, 8'h00, 1'b0, 32'h0,        1'b0, 5'd0,  1'b1, 1'b1, 32'h0,        1'b0, 8'h00};
      vecs[1]  = '{1'b1, 8'h10, 1'b0, 32'h0,        1'b0, 5'd0,  1'b1, 1'b1, 32'h0,        1'b0, 8'h00};
      vecs[2]  = '{1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 5'd3,  1'b1, 1'b1, 32'h3,        1'b0, 8'h03};
      vecs[3]  = '{1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 5'd0,  1'b1, 1'b1, 32'h3,        1'b1, 8'h03};
      vecs[4]  = '{1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 5'd17, 1'b1, 1'b1, 32'h3,        1'b1, 8'h03};
      vecs[5]  = '{1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 5'd0,  1'b1, 1'b1, 32'h3,        1'b0, 8'h03};
      vecs[6]  = '{1'b0, 8'h00, 1'b1, 32'h0000100A, 1'b0, 5'd0,  1'b0, 1'b1, 32'h0000100A, 1'b0, 8'h00};
      vecs[7]  = '{1'b1, 8'h20, 1'b0, 32'h0,        1'b0, 5'd0,  1'b0, 1'b1, 32'h0000100A, 1'b0, 8'h00};
      vecs[8]  = '{1'b1, 8'h30, 1'b0, 32'h0,        1'b0, 5'd0,  1'b1, 1'b1, 32'h0000100A, 1'b0, 8'h2A};
      vecs[9]  = '{1'b1, 8'h40, 1'b0, 32'h0,        1'b0, 5'd0,  1'b1, 1'b0, 32'h0000100A, 1'b0, 8'h2A};
      vecs[10] = '{1'b1, 8'h50, 1'b0, 32'h0,        1'b0, 5'd0,  1'b1, 1'b0, 32'h0000100A, 1'b0, 8'h2A};
      vecs[11] = '{1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 5'd16, 1'b1, 1'b1, 32'h0000101A, 1'b0, 8'h3A};
      vecs[12] = '{1'b0, 8'h00, 1'b1, 32'h00000200, 1'b0, 5'd0,  1'b0, 1'b1, 32'h00000200, 1'b0, 8'h00};
      vecs[13] = '{1'b1, 8'h60, 1'b0, 32'h0,        1'b0, 5'd0,  1'b1, 1'b1, 32'h00000200, 1'b0, 8'h60};
      vecs[14] = '{1'b1, 8'h70, 1'b0, 32'h0,        1'b0, 5'd0,  1'b1, 1'b1, 32'h00000200, 1'b0, 8'h60};
      vecs[15] = '{1'b1, 8'h80, 1'b0, 32'h0,        1'b0, 5'd0,  1'b1, 1'b0, 32'h00000200, 1'b0, 8'h60};
      vecs[16] = '{1'b1, 8'h90, 1'b0, 32'h0,        1'b0, 5'd0,  1'b1, 1'b0, 32'h00000200, 1'b0, 8'h60};
      vecs[17] = '{1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 5'd16, 1'b1, 1'b1, 32'h00000210, 1'b0, 8'h70};
      vecs[18] = '{1'b1, 8'hA0, 1'b1, 32'h00000300, 1'b1, 5'd4,  1'b0, 1'b1, 32'h00000300, 1'b0, 8'h00};
      vecs[19] = '{1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 5'd0,  1'b0, 1'b1, 32'h00000300, 1'b0, 8'h00};

      // ---- reset state ----
      repeat (3) @(posedge clk);
      #1;
      chk("reset pkt_valid", 128'(pkt_valid), 128'(1'b0));
      chk("reset line_ready", 128'(line_ready), 128'(1'b1));
      chk("reset packet", packet, 128'd0);
      chk("reset pkt_eip", 128'(pkt_eip), 128'd0);
      chk("reset len_err", 128'(len_err), 128'(1'b0));
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_model();

      // ---- directed table ----
      for (int v = 0; v < NV; v++) begin
         step(vecs[v].lv, seq_line(vecs[v].ln_start), vecs[v].fl, vecs[v].fe,
              vecs[v].pr, vecs[v].len);
         chk($sformatf("vec%0d pkt_valid", v), 128'(pkt_valid), 128'(vecs[v].e_valid));
         chk($sformatf("vec%0d line_ready", v), 128'(line_ready), 128'(vecs[v].e_ready));
         chk($sformatf("vec%0d pkt_eip", v), 128'(pkt_eip), 128'(vecs[v].e_eip));
         chk($sformatf("vec%0d len_err", v), 128'(len_err), 128'(vecs[v].e_lerr));
         chk($sformatf("vec%0d packet", v), packet,
             vecs[v].e_valid ? seq_line(vecs[v].e_head) : 128'd0);
      end

      // ---- continuous stream with 7-byte instructions; wraps the buffer ----
      step(1'b0, '0, 1'b1, 32'h0, 1'b0, 5'd0);
      nl = 0;
      for (int k = 0; k < 40; k++) begin
         acc = model_ready();
         step(1'b1, seq_line(8'(nl * 16)), 1'b0, 32'h0, 1'b1, 5'd7);
         if (acc) nl++;
      end

      // ---- random traffic ----
      for (int k = 0; k < 1500; k++) begin
         r_lv = ($urandom_range(0, 3) != 0);
         r_fl = ($urandom_range(0, 49) == 0);
         r_fe = $urandom;
         r_pr = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 9) == 0)
            r_len = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(17, 31));
         else
            r_len = 5'($urandom_range(1, 16));
         step(r_lv, {$urandom, $urandom, $urandom, $urandom}, r_fl, r_fe, r_pr, r_len);
      end

      // ---- asynchronous reset mid-stream ----
      step(1'b1, seq_line(8'hC0), 1'b0, 32'h0, 1'b0, 5'd0);
      #2;
      reset = 1'b0;
      #1;
      chk("midreset pkt_valid", 128'(pkt_valid), 128'(1'b0));
      chk("midreset line_ready", 128'(line_ready), 128'(1'b1));
      chk("midreset packet", packet, 128'd0);
      chk("midreset pkt_eip", 128'(pkt_eip), 128'd0);
      chk("midreset len_err", 128'(len_err), 128'(1'b0));
      model_reset();
      line_valid = 1'b0;
      flush      = 1'b0;
      pkt_ready  = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_model();
      step(1'b1, seq_line(8'hE0), 1'b0, 32'h0, 1'b1, 5'd5);
      step(1'b0, '0, 1'b0, 32'h0, 1'b1, 5'd5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
